// File: rtl/bsg_fifo_credit_sender.sv
// ---------------------------------------------------------------------------
// bsg_fifo_credit_sender
//
// Producer-side end of a credit-based link that feeds a remote FIFO. The
// block holds one credit for every free slot in the remote FIFO. It accepts
// a valid/ready stream and never sends a beat without a credit. Each
// registered output beat carries the remote slot index it will occupy. That
// index is a local copy of the remote tracker's write pointer. Credits come
// back one per cycle as the remote side dequeues.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_n_i    asynchronous active-low reset
//   v_i          upstream beat valid
//   data_i       upstream payload
//   ready_o      a credit is held; a beat is taken when v_i & ready_o
//   v_o          registered beat valid toward the link
//   data_o       registered payload
//   wptr_o       remote slot index of the current beat
//   credit_v_i   one credit returned this cycle
//   credits_o    credits currently held, 0..els_p
//   idle_o       all credits held (remote FIFO drained)
//   error_o      sticky: a returned credit would have exceeded els_p
// ---------------------------------------------------------------------------
module bsg_fifo_credit_sender #(
   parameter  int els_p    = 256,
   parameter  int width_p  = 8,
   localparam int ptr_w_lp = $clog2(els_p),
   localparam int cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                v_i,
   input  logic [width_p-1:0]  data_i,
   output logic                ready_o,
   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   output logic [ptr_w_lp-1:0] wptr_o,
   input  logic                credit_v_i,
   output logic [cnt_w_lp-1:0] credits_o,
   output logic                idle_o,
   output logic                error_o
);

   localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

   logic [cnt_w_lp-1:0] credits_r, credits_n;
   logic [ptr_w_lp-1:0] wptr_r;
   logic                error_r, error_n;
   logic                send;

   // Handshake and status come straight from registers. This keeps any
   // combinational path from the inputs away from ready_o.
   assign ready_o   = (credits_r != '0);
   assign send      = v_i & ready_o;
   assign credits_o = credits_r;
   assign idle_o    = (credits_r == full_lp);
   assign error_o   = error_r;

   // Credit arithmetic: a send spends a credit and a return adds one.
   // Both together cancel out. A return while already full is a protocol
   // violation by the remote side. The count saturates and the error flag
   // latches.
   always_comb begin
      credits_n = credits_r;
      error_n   = error_r;
      case ({send, credit_v_i})
         2'b10: credits_n = credits_r - cnt_w_lp'(1);
         2'b01: begin
            if (credits_r == full_lp) begin
               error_n = 1'b1;
            end else begin
               credits_n = credits_r + cnt_w_lp'(1);
            end
         end
         default: credits_n = credits_r;
      endcase
   end

   // State registers. The output beat is issued one cycle after a send. It
   // carries the pre-increment write pointer. Because els_p is a power of
   // two, the pointer wraps naturally at ptr_w_lp bits. data_o and wptr_o
   // hold their last values between beats.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credits_r <= full_lp;
         wptr_r    <= '0;
         error_r   <= 1'b0;
         v_o       <= 1'b0;
         data_o    <= '0;
         wptr_o    <= '0;
      end else begin
         credits_r <= credits_n;
         error_r   <= error_n;
         v_o       <= send;
         if (send) begin
            data_o <= data_i;
            wptr_o <= wptr_r;
            wptr_r <= wptr_r + ptr_w_lp'(1);
         end
      end
   end

endmodule
